// File: rtl/apb_arbiter_pkg.sv
// apb_arbiter_pkg: shared types and defaults for the APB arbiter.
// FSM state encoding, PPROT width and default parameter values.
package apb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int APB_PROT_W          = 3;
  localparam int DEF_NUM_MASTERS     = 2;
  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_TIMEOUT_CYCLES  = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_arbiter_rr_pick.sv
// apb_arbiter_rr_pick: combinational round-robin picker.
// Ports: req_i (requests), ptr_i (start index) -> valid_o, idx_o (first requester at/after ptr_i).
module apb_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin sharing of one APB slave among NUM_MASTERS masters.
// Ports: m_apb_* per-master APB (packed slices), s_apb_* shared slave side,
// grant_o one-hot grant. Optional macro APB_ARBITER_TIMEOUT_EN adds an
// ACCESS wait limit of TIMEOUT_CYCLES that completes with slverr=1.
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              apb_clk_i,
  input  logic                              apb_resetn_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_apb_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_apb_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_apb_enable_i,
  input  logic [NUM_MASTERS-1:0]            m_apb_write_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_apb_strb_i,
  input  logic [NUM_MASTERS*APB_PROT_W-1:0] m_apb_prot_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_apb_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_apb_ready_o,
  output logic [DATA_W-1:0]                 m_apb_rdata_o,
  output logic [NUM_MASTERS-1:0]            m_apb_slverr_o,
  output logic [ADDR_W-1:0]                 s_apb_addr_o,
  output logic                              s_apb_sel_o,
  output logic                              s_apb_enable_o,
  output logic                              s_apb_write_o,
  output logic [DATA_W/8-1:0]               s_apb_strb_o,
  output logic [APB_PROT_W-1:0]             s_apb_prot_o,
  output logic [DATA_W-1:0]                 s_apb_wdata_o,
  input  logic                              s_apb_ready_i,
  input  logic [DATA_W-1:0]                 s_apb_rdata_i,
  input  logic                              s_apb_slverr_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int SW = DATA_W / 8;

  state_e          state_q, state_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            s_sel, s_en;
  logic            done, err, fwd;
  logic [NUM_MASTERS-1:0] g_oh;

  // PENABLE from the masters carries no information the FSM needs.
  logic unused_ok;
  assign unused_ok = ^{m_apb_enable_i, 32'(TIMEOUT_CYCLES)};

`ifdef APB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  apb_arbiter_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i   (m_apb_sel_i),
    .ptr_i   (rr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
    end
  end

`ifdef APB_ARBITER_TIMEOUT_EN
  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    s_sel   = 1'b0;
    s_en    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    fwd     = 1'b0;
`ifdef APB_ARBITER_TIMEOUT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          g_d     = pick_idx;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        s_sel   = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        s_sel = 1'b1;
        s_en  = 1'b1;
        if (s_apb_ready_i) begin
          done = 1'b1;
          err  = s_apb_slverr_i;
          fwd  = 1'b1;
        end
`ifdef APB_ARBITER_TIMEOUT_EN
        // Counter holds the number of ACCESS cycles already waited.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          s_sel = 1'b0;
          s_en  = 1'b0;
          done  = 1'b1;
          err   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        if (done) begin
          rr_d    = (g_q == IW'(NUM_MASTERS - 1)) ? '0 : g_q + IW'(1);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign g_oh    = NUM_MASTERS'(1) << g_q;
  assign grant_o = (state_q == ST_IDLE) ? '0 : g_oh;

  assign s_apb_sel_o    = s_sel;
  assign s_apb_enable_o = s_en;
  assign s_apb_addr_o   = s_sel ? m_apb_addr_i[int'(g_q)*ADDR_W +: ADDR_W] : '0;
  assign s_apb_write_o  = s_sel ? m_apb_write_i[g_q] : 1'b0;
  assign s_apb_strb_o   = s_sel ? m_apb_strb_i[int'(g_q)*SW +: SW] : '0;
  assign s_apb_prot_o   = s_sel ? m_apb_prot_i[int'(g_q)*APB_PROT_W +: APB_PROT_W] : '0;
  assign s_apb_wdata_o  = s_sel ? m_apb_wdata_i[int'(g_q)*DATA_W +: DATA_W] : '0;

  assign m_apb_ready_o  = done ? g_oh : '0;
  assign m_apb_slverr_o = err ? g_oh : '0;
  assign m_apb_rdata_o  = fwd ? s_apb_rdata_i : '0;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: randomized and directed bench for apb_arbiter.
// Transaction-level master/slave models with a round-robin reference.
`timescale 1ns/1ps
module tb_apb_arbiter;
  import apb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            wt;
    bit            fix;
    logic [DW-1:0] rd;
    logic          err;
  } txn_t;

  logic clk = 1'b0;
  logic rstn;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_sel, m_en, m_wr;
  logic [N*SW-1:0] m_strb;
  logic [N*3-1:0]  m_prot;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_rdy, m_err, grant;
  logic [DW-1:0]   m_rdata;
  logic [AW-1:0]   s_addr;
  logic            s_sel, s_en, s_wr;
  logic [SW-1:0]   s_strb;
  logic [2:0]      s_prot;
  logic [DW-1:0]   s_wdata;
  logic            s_rdy, s_err;
  logic [DW-1:0]   s_rdata;

  always #5 clk = ~clk;

  apb_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .apb_clk_i(clk), .apb_resetn_i(rstn),
    .m_apb_addr_i(m_addr), .m_apb_sel_i(m_sel), .m_apb_enable_i(m_en),
    .m_apb_write_i(m_wr), .m_apb_strb_i(m_strb), .m_apb_prot_i(m_prot),
    .m_apb_wdata_i(m_wdata), .m_apb_ready_o(m_rdy), .m_apb_rdata_o(m_rdata),
    .m_apb_slverr_o(m_err), .s_apb_addr_o(s_addr), .s_apb_sel_o(s_sel),
    .s_apb_enable_o(s_en), .s_apb_write_o(s_wr), .s_apb_strb_o(s_strb),
    .s_apb_prot_o(s_prot), .s_apb_wdata_o(s_wdata), .s_apb_ready_i(s_rdy),
    .s_apb_rdata_i(s_rdata), .s_apb_slverr_i(s_err), .grant_o(grant)
  );

  int n_chk = 0;
  int n_fail = 0;

  txn_t mq[N][$];
  txn_t ct[N];
  int ms[N];
  int t_set[N], lat[N], waitn[N], rdy_cnt[N];
  logic [DW-1:0] got_rd[N];
  logic got_err[N];
  int served[$];
  int ph, cur, last, acc_n, sl_left, cyc;
  logic [DW-1:0] sl_rd;
  logic sl_err;
  bit auto_on;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] req, input int lst);
    for (int i = 1; i <= N; i++)
      if (req[(lst + i) % N]) return (lst + i) % N;
    return 0;
  endfunction

  function automatic txn_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic w, input int wt);
    txn_t t;
    t.addr = a; t.wdata = d; t.wr = w; t.strb = 4'hF; t.prot = 3'd0;
    t.wt = wt; t.fix = 1'b0; t.rd = '0; t.err = 1'b0;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    t = mk($urandom & 32'hFFFC, $urandom, 1'($urandom_range(1)), -1);
    t.strb = 4'($urandom);
    t.prot = 3'($urandom);
    return t;
  endfunction

  task automatic drive_masters();
    for (int k = 0; k < N; k++) begin
      m_sel[k] = (ms[k] != 0);
      m_en[k]  = (ms[k] == 2);
      m_wr[k]  = ct[k].wr;
      m_addr[k*AW +: AW]  = ct[k].addr;
      m_wdata[k*DW +: DW] = ct[k].wdata;
      m_strb[k*SW +: SW]  = ct[k].strb;
      m_prot[k*3 +: 3]    = ct[k].prot;
    end
  endtask

  task automatic step();
    logic [N-1:0] er, ee;
    logic [DW-1:0] erd;
    bit fin;
    int nph;
    drive_masters();
    nph = ph;
    if (ph == 0 && m_sel != '0) begin
      cur = rr_next(m_sel, last);
      nph = 1;
    end
    if (ph == 1) begin
      sl_left = (ct[cur].wt >= 0) ? ct[cur].wt : $urandom_range(3);
      sl_rd   = ct[cur].fix ? ct[cur].rd : $urandom;
      sl_err  = ct[cur].fix ? ct[cur].err : 1'($urandom_range(1));
    end
    if (ph == 2) begin
      s_rdy = (sl_left == 0); s_rdata = sl_rd; s_err = sl_err;
    end else begin
      s_rdy = 1'($urandom_range(1)); s_rdata = $urandom;
      s_err = 1'($urandom_range(1));
    end
    #2;
    er = '0; ee = '0; erd = '0; fin = 1'b0;
    case (ph)
      0: begin
        chk("idle_sel", s_sel, 0);
        chk("idle_grant", grant, 0);
      end
      1: begin
        chk("setup_grant", grant, N'(1) << cur);
        chk("setup_phase", {s_sel, s_en}, 2'b10);
        chk("setup_addr", s_addr, ct[cur].addr);
        chk("setup_wdata", s_wdata, ct[cur].wdata);
        chk("setup_ctl", {s_wr, s_strb, s_prot},
            {ct[cur].wr, ct[cur].strb, ct[cur].prot});
        nph = 2;
        acc_n = 0;
      end
      2: begin
        acc_n++;
`ifdef APB_ARBITER_TIMEOUT_EN
        if (acc_n > TO) begin
          chk("tmo_phase", {s_sel, s_en}, 2'b00);
          er[cur] = 1'b1; ee[cur] = 1'b1; erd = '0; fin = 1'b1;
        end else
`endif
        begin
          chk("acc_phase", {s_sel, s_en}, 2'b11);
          chk("acc_grant", grant, N'(1) << cur);
          chk("acc_addr", s_addr, ct[cur].addr);
          if (s_rdy) begin
            er[cur] = 1'b1; ee[cur] = sl_err; erd = sl_rd; fin = 1'b1;
          end else begin
            sl_left--;
          end
        end
        if (fin) nph = 3;
      end
      default: begin
        chk("done_sel", s_sel, 0);
        chk("done_grant", grant, N'(1) << cur);
        nph = 0;
      end
    endcase
    chk("m_ready", m_rdy, er);
    chk("m_slverr", m_err, ee);
    if (fin) begin
      chk("m_rdata", m_rdata, erd);
      chk("fair_wait", waitn[cur] <= N - 1, 1);
      last = cur;
      served.push_back(cur);
      lat[cur] = cyc - t_set[cur];
      got_rd[cur] = m_rdata;
      got_err[cur] = m_err[cur];
      for (int k = 0; k < N; k++)
        if (k != cur && ms[k] != 0) waitn[k]++;
    end
    ph = nph;
    for (int k = 0; k < N; k++) begin
      rdy_cnt[k] += int'(m_rdy[k]);
      if (ms[k] == 2 && er[k]) ms[k] = 0;
      else if (ms[k] == 1) ms[k] = 2;
      if (ms[k] == 0 && auto_on && mq[k].size() == 0 &&
          $urandom_range(99) < 35)
        mq[k].push_back(rnd());
      if (ms[k] == 0 && mq[k].size() != 0) begin
        ct[k] = mq[k].pop_front();
        ms[k] = 1;
        t_set[k] = cyc + 1;
        waitn[k] = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      ms[k] = 0; mq[k].delete(); waitn[k] = 0; rdy_cnt[k] = 0;
      lat[k] = -1; got_rd[k] = '0; got_err[k] = 1'b0;
    end
    served.delete();
    ph = 0; last = N - 1; cur = 0; acc_n = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s_rdy = 1'b1; s_err = 1'b1; s_rdata = '1;
    @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_s_phase", {s_sel, s_en, s_wr}, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_s_ctl", {s_strb, s_prot}, 0);
    chk("rst_m_ready", m_rdy, 0);
    chk("rst_m_slverr", m_err, 0);
    chk("rst_m_rdata", m_rdata, 0);
    clear_model();
    drive_masters();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic run_drain(input string tag, input int max);
    int n;
    bit busy;
    n = 0;
    do begin
      step();
      n++;
      busy = (ph != 0);
      for (int k = 0; k < N; k++)
        if (ms[k] != 0 || mq[k].size() != 0) busy = 1'b1;
    end while (busy && n < max);
    chk({tag, "_drain"}, n < max, 1);
  endtask

  initial begin
    txn_t t;
    rstn = 1'b0;
    auto_on = 1'b0;
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      ct[k] = mk('0, '0, 1'b0, 0);
      t_set[k] = 0;
    end
    clear_model();
    drive_masters();
    do_reset();

    mq[0].push_back(mk(32'h10, 32'hA5A5_A5A5, 1'b1, 0));
    run_drain("t1", 50);
    chk("t1_latency", lat[0], 2);
    chk("t1_ready_pulses", rdy_cnt[0], 1);

    do_reset();
    mq[0].push_back(mk(32'h100, 32'h1111_0000, 1'b1, 0));
    mq[1].push_back(mk(32'h200, 32'h2222_0000, 1'b1, 0));
    run_drain("t2", 50);
    chk("t2_count", served.size(), 2);
    if (served.size() == 2) begin
      chk("t2_first", served[0], 0);
      chk("t2_second", served[1], 1);
    end
    chk("t2_m1_latency", lat[1], 6);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      mq[0].push_back(mk(32'h300 + 32'(i), 32'($urandom), 1'b1, 0));
      mq[1].push_back(mk(32'h400 + 32'(i), 32'($urandom), 1'b0, 1));
    end
    run_drain("t3", 80);
    chk("t3_count", served.size(), 4);
    for (int i = 0; i < 4 && i < served.size(); i++)
      chk($sformatf("t3_order%0d", i), served[i], i % 2);

    do_reset();
    t = mk(32'h40, '0, 1'b0, 3);
    t.fix = 1'b1; t.rd = 32'hDEAD_BEEF; t.err = 1'b1;
    mq[0].push_back(t);
    run_drain("t4", 50);
    chk("t4_rdata", got_rd[0], 32'hDEAD_BEEF);
    chk("t4_slverr", got_err[0], 1);
    chk("t4_latency", lat[0], 5);

    do_reset();
    mq[0].push_back(mk(32'h50, 32'h5, 1'b1, 5));
    for (int i = 0; i < 10 && ph != 2; i++) step();
    chk("t5_reached_access", ph, 2);
    do_reset();
    mq[1].push_back(mk(32'h60, 32'h6, 1'b1, 0));
    run_drain("t5", 50);
    chk("t5_count", served.size(), 1);
    chk("t5_latency", lat[1], 2);

`ifdef APB_ARBITER_TIMEOUT_EN
    do_reset();
    mq[0].push_back(mk(32'h70, '0, 1'b0, 1000));
    mq[1].push_back(mk(32'h80, 32'h8, 1'b1, 0));
    run_drain("tmo", 100);
    chk("tmo_slverr", got_err[0], 1);
    chk("tmo_rdata", got_rd[0], 0);
    chk("tmo_latency", lat[0], 2 + TO);
    chk("tmo_count", served.size(), 2);
    if (served.size() == 2) chk("tmo_next", served[1], 1);
`endif

    do_reset();
    auto_on = 1'b1;
    repeat (800) step();
    auto_on = 1'b0;
    run_drain("rand", 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
